// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: exception codes,
// CP0 register addresses, the forwarded Cause field mask and FSM encodings.
// Also holds the interrupt-pending rule so every user evaluates it identically.
package exc_ctrl_pkg;

  // Encoded exception types driven to CP0
  localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INV_INST  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

  // CP0 register numbers seen on the WB mtc0 path
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Cause bits software may write: IP1..IP0 [9:8], IV 23, WP 22
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  // Raw MEM-stage exception flag positions
  localparam int RAW_SYSCALL  = 8;
  localparam int RAW_INV_INST = 9;
  localparam int RAW_TRAP     = 10;
  localparam int RAW_OVERFLOW = 11;
  localparam int RAW_ERET     = 12;

  // Controller states
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  // Enabled pending line, interrupts enabled, not already in exception level
  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return ((cause[15:8] & status[15:8]) != 8'h00) && !status[1] && status[0];
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous level inputs.
// Latency: STAGES clock edges from d_i to q_o; async active-low clear.
// No backpressure: free-running, samples every cycle.
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  // Shift the raw lines one stage down the chain each cycle
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception resolver: forwards WB mtc0, prioritises, flushes and redirects.
// Latency: outputs combinational in cycle N; cycle N+1 is a forced quiet SQUASH cycle.
// No backpressure: a taken exception always flushes; SQUASH suppresses a repeat take.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_i,
  input  logic [31:0] mem_excepttype_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [31:0] status_f;
  logic [31:0] cause_f;
  logic [31:0] epc_f;
  logic        unused_raw_bits;

  assign unused_raw_bits = ^{mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

  int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (int_i),
    .q_o   (int_sync_o)
  );

  // Effective CP0 view including the mtc0 still sitting in WB
  always_comb begin
    status_f = cp0_status_i;
    cause_f  = cp0_cause_i;
    epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_REG_STATUS) status_f = wb_cp0_data_i;
      if (wb_cp0_waddr_i == CP0_REG_CAUSE) begin
        cause_f = (cp0_cause_i & ~CAUSE_WR_MASK) | (wb_cp0_data_i & CAUSE_WR_MASK);
      end
      if (wb_cp0_waddr_i == CP0_REG_EPC) epc_f = wb_cp0_data_i;
    end
  end

  // Priority encode for a valid instruction in RUN, then derive flush and target
  always_comb begin
    excepttype_o = EXC_NONE;
    if (state_q == ST_RUN && mem_pc_i != 32'h0) begin
      if (int_pending(status_f, cause_f))     excepttype_o = EXC_INTERRUPT;
      else if (mem_excepttype_i[RAW_SYSCALL])  excepttype_o = EXC_SYSCALL;
      else if (mem_excepttype_i[RAW_INV_INST]) excepttype_o = EXC_INV_INST;
      else if (mem_excepttype_i[RAW_TRAP])     excepttype_o = EXC_TRAP;
      else if (mem_excepttype_i[RAW_OVERFLOW]) excepttype_o = EXC_OVERFLOW;
      else if (mem_excepttype_i[RAW_ERET])     excepttype_o = EXC_ERET;
    end
    flush_o  = (excepttype_o != EXC_NONE);
    new_pc_o = 32'h0;
    if (excepttype_o == EXC_ERET)      new_pc_o = epc_f;
    else if (flush_o)                  new_pc_o = EXC_VECTOR;
  end

  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_is_in_delayslot_i;

  // One quiet cycle after every take while CP0 EXL/EPC update
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (flush_o) state_d = ST_SQUASH;
      ST_SQUASH: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception control unit for the tinyMIPS core, sitting at the MEM stage. It is the producer side of the CP0 exception interface. It synchronises external interrupt lines into CP0 and reads back CP0 Status/Cause/EPC, with forwarding of in-flight `mtc0` writes from WB. It then resolves the prioritised exception for the MEM-stage instruction, drives the CP0 `excepttype`/PC/delay-slot inputs, and issues the pipeline flush and redirect PC.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h00000020: redirect PC for every exception except ERET.
- `SYNC_STAGES`, 2: flip-flop depth of the interrupt synchroniser (≥2).

Ports:
- `clk`  in  1: core clock.
- `rst_n`  in  1: asynchronous reset, active-low. Reset is asserted asynchronously and released synchronously to `clk` by the top level.
- `int_i`  in  6: raw external interrupt lines, asynchronous to `clk`.
- `mem_excepttype_i`  in  32: MEM-stage raw exception flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret.
- `mem_pc_i`  in  32: MEM-stage instruction address; 0 means bubble.
- `mem_is_in_delayslot_i`  in  1: MEM instruction is in a delay slot.
- `cp0_status_i`, `cp0_cause_i`, `cp0_epc_i`  in  32 each: current CP0 register values.
- `wb_cp0_we_i`  in  1: WB-stage `mtc0` write enable.
- `wb_cp0_waddr_i`  in  5: WB `mtc0` register address.
- `wb_cp0_data_i`  in  32: WB `mtc0` data.
- `int_sync_o`  out  6: synchronised interrupts, driven to CP0 `int_i`.
- `excepttype_o`  out  32: encoded exception driven to CP0.
- `current_inst_addr_o`  out  32: equals `mem_pc_i`.
- `is_in_delayslot_o`  out  1: equals `mem_is_in_delayslot_i`.
- `flush_o`  out  1: flush all pipeline registers.
- `new_pc_o`  out  32: redirect target, valid while `flush_o`=1.

## Operation
- Forwarding produces the effective registers `status_f`, `cause_f`, `epc_f`:
  - `status_f` is `wb_cp0_data_i` when `wb_cp0_we_i` and waddr=12, otherwise `cp0_status_i`.
  - `cause_f` is `cp0_cause_i` with bits [9:8], 22 and 23 replaced from `wb_cp0_data_i` when waddr=13.
  - `epc_f` is `wb_cp0_data_i` when waddr=14, otherwise `cp0_epc_i`.
- Interrupt pending: `((cause_f[15:8] & status_f[15:8]) != 0) && status_f[1]==0 && status_f[0]==1`.
- Encoding applies only when `mem_pc_i != 0` and state is RUN; otherwise `excepttype_o`=0. Priority, highest first:
  - interrupt → 32'h1
  - bit8 → 32'h8
  - bit9 → 32'ha
  - bit10 → 32'hd
  - bit11 → 32'hc
  - bit12 → 32'he
  - none → 0
- `flush_o` = (`excepttype_o` != 0).
- `new_pc_o` = `epc_f` for 32'he, `EXC_VECTOR` for any other nonzero code, 0 when no flush.
- State machine, registered:
  - RUN → SQUASH when `excepttype_o` != 0.
  - SQUASH → RUN unconditionally.
  - In SQUASH, `excepttype_o`, `flush_o` and `new_pc_o` are forced to 0. This blocks a second take of the same event while CP0 EXL/EPC settle.
- Synchroniser: `SYNC_STAGES`-deep flop chain per line. `int_sync_o` is the last stage.

## Timing
- Reset values: `int_sync_o`=0, state=RUN. `excepttype_o`, `flush_o` and `new_pc_o` are therefore 0.
- `excepttype_o`, `flush_o`, `new_pc_o`, `current_inst_addr_o` and `is_in_delayslot_o` are combinational. CP0 and pipeline registers capture them at the edge ending cycle N.
- Cycle N+1 is always SQUASH, so no exception output is possible. Normal operation resumes at N+2.
- Interrupt latency: an `int_i` edge appears on `int_sync_o` after `SYNC_STAGES` edges. CP0 Cause[15:10] follows one edge later, and the interrupt is taken on the first RUN cycle with a valid MEM instruction.
- Simultaneous WB `mtc0` to Status clearing IE and a pending interrupt: the forwarded value wins, so no interrupt is taken.
- ERET with a simultaneous WB write to EPC: `new_pc_o` is the forwarded data.
- Interrupt coincident with syscall: the interrupt (32'h1) wins.
- Reset asserted mid-SQUASH: state returns to RUN immediately and the synchroniser clears.

## Structure
- Exception codes (1, 8, a, c, d, e), CP0 register addresses (12, 13, 14) and `EXC_VECTOR` belong in `macro.v` as `EXC_*`/`CP0_REG_*` defines.
- One sub-module: `int_sync`, a parameterised multi-bit synchroniser with asynchronous active-low clear, instantiated once for 6 bits.

## Test plan
- Syscall, with Status=32'h10000000, `mem_pc_i`=32'h100, bit8 set:
  - `excepttype_o`=32'h8, `flush_o`=1, `new_pc_o`=32'h20.
  - Next cycle all outputs are 0.
- ERET, with `cp0_epc_i`=32'h200 and a WB `mtc0` EPC ← 32'h300 in the same cycle: `excepttype_o`=32'he, `new_pc_o`=32'h300.
- Timer interrupt, with Status=32'h00008001 and `int_i[5]` rising:
  - `int_sync_o[5]`=1 after 2 edges.
  - With Cause[15]=1 and a valid MEM PC, `excepttype_o`=32'h1.
- Masked interrupt, with Status EXL=1 and IE=1 (32'h00008003), pending IP7: `excepttype_o`=0.
- Priority and bubble:
  - Overflow plus invalid inst at the same time gives 32'ha.
  - The same flags with `mem_pc_i`=0 give 0.
- Reset mid-operation: `rst_n` low during SQUASH gives state RUN and `int_sync_o`=0 immediately; the first RUN cycle after release can take an exception.
